// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//
// Owns the single write port of the capability register file. It has CW-bit
// entries, with the tag bit included, and x0 is hardwired to zero.
//
// Two writeback requesters compete for the port:
// - ALU / capability unit.
// - Load/store unit. The LSU has priority.
// A starvation counter forces one ALU win after the ALU has been denied
// STARVE_LIMIT times.
//
// A clear sequencer zeroes a masked set of registers, one per cycle, for
// CClearRegs-style operations. Every write, whether from a requester or from
// the clear sequencer, passes through one register stage before it reaches
// the register file port.
//
// Optional build macro: RF_WB_ARB_STATS_EN adds two saturating stall counters
// (stall_cnt_alu, stall_cnt_lsu) for CPI breakdown.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   alu_valid/wa/wd/ready  ALU writeback request and handshake
//   lsu_valid/wa/wd/ready  LSU writeback request and handshake
//   clr_start, clr_mask    start a clear of the registers set in the mask
//   clr_busy, clr_done     clear in progress / one-cycle completion pulse
//   rf_we, rf_wa, rf_wd    registered register-file write port
//   stall_cnt_alu/lsu      (RF_WB_ARB_STATS_EN only) denied-cycle counters

module rf_wb_arbiter #(
    parameter int unsigned CW           = 129,
    parameter int unsigned AW           = 5,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          alu_valid,
    input  logic [AW-1:0] alu_wa,
    input  logic [CW-1:0] alu_wd,
    output logic          alu_ready,

    input  logic          lsu_valid,
    input  logic [AW-1:0] lsu_wa,
    input  logic [CW-1:0] lsu_wd,
    output logic          lsu_ready,

    input  logic          clr_start,
    input  logic [31:0]   clr_mask,
    output logic          clr_busy,
    output logic          clr_done,

    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [CW-1:0] rf_wd
`ifdef RF_WB_ARB_STATS_EN
    ,
    output logic [31:0]   stall_cnt_alu,
    output logic [31:0]   stall_cnt_lsu
`endif
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [0:0] {
        StIdle,
        StScan
    } state_e;

    state_e        state_q,    state_d;
    logic [31:0]   rem_q,      rem_d;
    logic [SW-1:0] starve_q,   starve_d;
    logic          rf_we_q,    rf_we_d;
    logic [AW-1:0] rf_wa_q,    rf_wa_d;
    logic [CW-1:0] rf_wd_q,    rf_wd_d;
    logic          clr_done_q, clr_done_d;

    // ------------------------------------------------------------------
    // Grant logic
    // ------------------------------------------------------------------
    logic grant_open;
    logic starved;
    logic alu_gnt;
    logic lsu_gnt;

    // Requesters are only served in IDLE and without a competing clear start.
    // Readies are also held low while reset is asserted.
    assign grant_open = rst_n && (state_q == StIdle) && !clr_start;
    assign starved    = (starve_q == SW'(STARVE_LIMIT));

    // Both grants are written directly in terms of the inputs, so neither
    // ready depends on the other.
    assign alu_gnt = grant_open && alu_valid && (!lsu_valid || starved);
    assign lsu_gnt = grant_open && lsu_valid && !(alu_valid && starved);

    assign alu_ready = alu_gnt;
    assign lsu_ready = lsu_gnt;

    // ------------------------------------------------------------------
    // Lowest set bit of the remaining clear mask
    // ------------------------------------------------------------------
    logic [AW-1:0] low_idx;

    always_comb begin
        low_idx = '0;
        // Scanning downwards lets the lowest set bit overwrite the others.
        for (int i = 31; i >= 0; i--) begin
            if (rem_q[i]) begin
                low_idx = AW'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        starve_d   = starve_q;
        rf_we_d    = 1'b0;
        rf_wa_d    = rf_wa_q;
        rf_wd_d    = rf_wd_q;
        clr_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (clr_start) begin
                    // Bit 0 is dropped: x0 is never written.
                    rem_d   = clr_mask & ~32'h1;
                    state_d = StScan;
                end else if (alu_gnt) begin
                    starve_d = '0;
                    if (alu_wa != '0) begin
                        rf_we_d = 1'b1;
                        rf_wa_d = alu_wa;
                        rf_wd_d = alu_wd;
                    end
                end else if (lsu_gnt) begin
                    // Count only the cycles where the ALU was denied by the LSU.
                    if (alu_valid && !starved) begin
                        starve_d = starve_q + SW'(1);
                    end
                    // A write to x0 completes the handshake but does not
                    // touch the port.
                    if (lsu_wa != '0) begin
                        rf_we_d = 1'b1;
                        rf_wa_d = lsu_wa;
                        rf_wd_d = lsu_wd;
                    end
                end
            end

            StScan: begin
                if (rem_q != '0) begin
                    rem_d   = rem_q & (rem_q - 32'd1);
                    rf_we_d = 1'b1;
                    rf_wa_d = low_idx;
                    rf_wd_d = '0;
                end else begin
                    // The registered done pulse lines up with busy dropping.
                    clr_done_d = 1'b1;
                    state_d    = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rem_q      <= '0;
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_wa_q    <= '0;
            rf_wd_q    <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_wa_q    <= rf_wa_d;
            rf_wd_q    <= rf_wd_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_wa    = rf_wa_q;
    assign rf_wd    = rf_wd_q;
    assign clr_busy = (state_q == StScan);
    assign clr_done = clr_done_q;

`ifdef RF_WB_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Stall statistics, saturating
    // ------------------------------------------------------------------
    logic [31:0] stall_alu_q;
    logic [31:0] stall_lsu_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_alu_q <= '0;
            stall_lsu_q <= '0;
        end else begin
            if (alu_valid && !alu_gnt && (stall_alu_q != '1)) begin
                stall_alu_q <= stall_alu_q + 32'd1;
            end
            if (lsu_valid && !lsu_gnt && (stall_lsu_q != '1)) begin
                stall_lsu_q <= stall_lsu_q + 32'd1;
            end
        end
    end

    assign stall_cnt_alu = stall_alu_q;
    assign stall_cnt_lsu = stall_lsu_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter.
//
// A queue-based model tracks the expected port behaviour, and a compare
// process checks every output on each falling edge. Directed scenarios add
// hand-computed literal checks on top of the model.

module tb_rf_wb_arbiter;

    localparam int CW = 129;
    localparam int AW = 5;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0;
    logic [AW-1:0] alu_wa = '0;
    logic [CW-1:0] alu_wd = '0;
    logic          alu_ready;
    logic          lsu_valid = 1'b0;
    logic [AW-1:0] lsu_wa = '0;
    logic [CW-1:0] lsu_wd = '0;
    logic          lsu_ready;
    logic          clr_start = 1'b0;
    logic [31:0]   clr_mask = '0;
    logic          clr_busy;
    logic          clr_done;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [CW-1:0] rf_wd;
`ifdef RF_WB_ARB_STATS_EN
    logic [31:0]   stall_cnt_alu;
    logic [31:0]   stall_cnt_lsu;
`endif

    rf_wb_arbiter #(
        .CW           (CW),
        .AW           (AW),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_wa    (alu_wa),
        .alu_wd    (alu_wd),
        .alu_ready (alu_ready),
        .lsu_valid (lsu_valid),
        .lsu_wa    (lsu_wa),
        .lsu_wd    (lsu_wd),
        .lsu_ready (lsu_ready),
        .clr_start (clr_start),
        .clr_mask  (clr_mask),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd)
`ifdef RF_WB_ARB_STATS_EN
        ,
        .stall_cnt_alu (stall_cnt_alu),
        .stall_cnt_lsu (stall_cnt_lsu)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    bit            m_scan = 0;
    int            m_q[$];
    int            m_starve = 0;
    logic          m_we = 0;
    logic [AW-1:0] m_wa = '0;
    logic [CW-1:0] m_wd = '0;
    logic          m_done = 0;
    longint        m_sa = 0;
    longint        m_sl = 0;
    int            m_k;
    logic          m_ar, m_lr;
    logic          c_ar, c_lr;

    // Who may transfer this cycle, given the current inputs and model state.
    function automatic void grant(output logic ar, output logic lr);
        ar = 1'b0;
        lr = 1'b0;
        if (rst_n && !m_scan && !clr_start) begin
            if (lsu_valid && alu_valid && m_starve == SL) ar = 1'b1;
            else if (lsu_valid)                           lr = 1'b1;
            else if (alu_valid)                           ar = 1'b1;
        end
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_scan = 0; m_q.delete(); m_starve = 0;
            m_we = 0; m_wa = '0; m_wd = '0; m_done = 0;
            m_sa = 0; m_sl = 0;
        end else begin
            grant(m_ar, m_lr);
            if (alu_valid && !m_ar && m_sa < 64'hFFFF_FFFF) m_sa++;
            if (lsu_valid && !m_lr && m_sl < 64'hFFFF_FFFF) m_sl++;
            m_we = 0;
            m_done = 0;
            if (m_scan) begin
                if (m_q.size() == 0) begin
                    m_done = 1;
                    m_scan = 0;
                end else begin
                    m_k = m_q.pop_front();
                    m_we = 1; m_wa = AW'(m_k); m_wd = '0;
                end
            end else if (clr_start) begin
                m_q.delete();
                for (int i = 1; i < 32; i++) if (clr_mask[i]) m_q.push_back(i);
                m_scan = 1;
            end else if (m_ar) begin
                m_starve = 0;
                if (alu_wa != 0) begin m_we = 1; m_wa = alu_wa; m_wd = alu_wd; end
            end else if (m_lr) begin
                if (alu_valid && m_starve < SL) m_starve++;
                if (lsu_wa != 0) begin m_we = 1; m_wa = lsu_wa; m_wd = lsu_wd; end
            end
        end
    end

    // Compare process: every output against the model, each falling edge.
    initial forever begin
        @(negedge clk);
        grant(c_ar, c_lr);
        chk("alu_ready", alu_ready, c_ar);
        chk("lsu_ready", lsu_ready, c_lr);
        chk("rf_we",     rf_we,     m_we);
        chk("rf_wa",     rf_wa,     m_wa);
        chk("rf_wd",     rf_wd,     m_wd);
        chk("clr_busy",  clr_busy,  m_scan);
        chk("clr_done",  clr_done,  m_done);
`ifdef RF_WB_ARB_STATS_EN
        chk("stall_cnt_alu", stall_cnt_alu, m_sa[31:0]);
        chk("stall_cnt_lsu", stall_cnt_lsu, m_sl[31:0]);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    localparam logic [CW-1:0] DW = 129'h1_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    bit we_t[5]   = '{0, 1, 1, 1, 0};
    int wa_t[5]   = '{0, 1, 4, 31, 31};
    bit busy_t[5] = '{1, 1, 1, 1, 0};
    bit done_t[5] = '{0, 0, 0, 0, 1};

    initial begin
        // Reset state, with a request pending while in reset.
        alu_valid = 1'b1;
        alu_wa = 5'd1;
        @(negedge clk);
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_clr_busy", clr_busy, 0);
        alu_valid = 1'b0;
        step();
        rst_n = 1'b1;

        // Single ALU write.
        step();
        alu_valid = 1; alu_wa = 5'd5; alu_wd = DW;
        @(negedge clk);
        chk("alu1_ready", alu_ready, 1);
        step();
        alu_valid = 0;
        @(negedge clk);
        chk("alu1_we", rf_we, 1);
        chk("alu1_wa", rf_wa, 5);
        chk("alu1_wd", rf_wd, DW);

        // Simultaneous requests: LSU x4, then ALU, then LSU again.
        step();
        alu_valid = 1; alu_wa = 5'd9; alu_wd = 129'h0_1111_2222;
        lsu_valid = 1; lsu_wa = 5'd3; lsu_wd = 129'h1_0000_3333;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("sim_lsu_ready", lsu_ready, (c != 4));
            chk("sim_alu_ready", alu_ready, (c == 4));
            if (c == 5) chk("sim_alu_wa", rf_wa, 9);
            step();
            if (c != 4) lsu_wa = lsu_wa + 5'd1;
        end
        @(negedge clk);
        chk("sim_last_wa", rf_wa, 7);

        // Write to x0.
        alu_valid = 0; lsu_wa = 5'd0;
        @(negedge clk);
        chk("x0_ready", lsu_ready, 1);
        step();
        lsu_valid = 0;
        @(negedge clk);
        chk("x0_we", rf_we, 0);
        chk("x0_wa_hold", rf_wa, 7);

        // Clear sequence with both requesters pushing.
        step();
        clr_mask = 32'h8000_0013; clr_start = 1;
        alu_valid = 1; lsu_valid = 1; lsu_wa = 5'd8;
        @(negedge clk);
        chk("clr_start_alu_ready", alu_ready, 0);
        chk("clr_start_lsu_ready", lsu_ready, 0);
        step();
        clr_start = 0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("clr_we", rf_we, we_t[s]);
            if (we_t[s]) begin
                chk("clr_wa", rf_wa, wa_t[s]);
                chk("clr_wd", rf_wd, 0);
            end
            chk("clr_busy", clr_busy, busy_t[s]);
            chk("clr_done", clr_done, done_t[s]);
            if (s < 4) chk("clr_ready", alu_ready | lsu_ready, 0);
            step();
            if (s == 3) begin alu_valid = 0; lsu_valid = 0; end
        end

        // Mask of x0 only, with a second start while busy.
        clr_mask = 32'h1; clr_start = 1;
        @(negedge clk);
        chk("e_busy0", clr_busy, 0);
        step();
        @(negedge clk);
        chk("e_busy1", clr_busy, 1);
        chk("e_we1", rf_we, 0);
        chk("e_done1", clr_done, 0);
        step();
        clr_start = 0;
        @(negedge clk);
        chk("e_busy2", clr_busy, 0);
        chk("e_done2", clr_done, 1);
        chk("e_we2", rf_we, 0);
        step();
        @(negedge clk);
        chk("e_busy3", clr_busy, 0);
        chk("e_done3", clr_done, 0);

        // Reset in the middle of a clear.
        step();
        clr_mask = 32'h0000_00F0; clr_start = 1;
        step();
        clr_start = 0;
        step();
        step();
        @(negedge clk);
        chk("mid_we", rf_we, 1);
        chk("mid_wa", rf_wa, 5);
        @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("rstm_we", rf_we, 0);
        chk("rstm_wa", rf_wa, 0);
        chk("rstm_wd", rf_wd, 0);
        chk("rstm_busy", clr_busy, 0);
        chk("rstm_done", clr_done, 0);
        alu_valid = 1; alu_wa = 5'd2; alu_wd = 129'h0_ABCD;
        @(negedge clk);
        chk("rstm_alu_ready", alu_ready, 0);
        step();
        step();
        rst_n = 1;
        @(negedge clk);
        chk("post_alu_ready", alu_ready, 1);
        chk("post_busy", clr_busy, 0);
        step();
        alu_valid = 0;
        @(negedge clk);
        chk("post_wa", rf_wa, 2);
        chk("post_done", clr_done, 0);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
